// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DefWidth : default operand/quotient/remainder width
//   state_e  : controller state encoding (IDLE, CALC, DONE)
package div_pkg;

  localparam int unsigned DefWidth = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor6.sv
// Trial subtractor used by the restoring divider.
// Ports:
//   a          : minuend
//   b          : subtrahend
//   diff       : a - b, modulo 2**WIDTH
//   borrow_out : 1 when b > a
module subtractor6 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div6_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin a division (accepted in IDLE or DONE)
//   dividend  : unsigned dividend, captured on accepted start
//   divisor   : unsigned divisor, captured on accepted start
//   busy      : high while iterating (CALC)
//   done      : one-cycle pulse, results valid
//   quotient  : result quotient, held until the next accepted start
//   remainder : result remainder, held until the next accepted start
//   dbz       : divide-by-zero flag, valid with done
// Optional feature: define DIV6_SEQ_DIVZERO_EN to short-circuit divisor 0
// straight to DONE with dbz=1. Otherwise dbz is tied low and divisor 0 runs
// the normal iteration (quotient all-ones, remainder = dividend).
module div6_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the dividend bits still to be consumed in the upper part and the
  // quotient bits produced so far in the lower part.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic             trial_borrow;

  assign shifted = {rem_q, quo_q[WIDTH-1]};

  subtractor6 #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a         (shifted[WIDTH-1:0]),
    .b         (dvs_q),
    .diff      (sub_diff),
    .borrow_out(sub_borrow)
  );

  // A set top bit means the shifted remainder already exceeds any divisor.
  assign trial_borrow = sub_borrow & ~shifted[WIDTH];

`ifdef DIV6_SEQ_DIVZERO_EN
  logic dbz_q, dbz_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef DIV6_SEQ_DIVZERO_EN
    dbz_d   = dbz_q;
`endif

    unique case (state_q)
      StIdle: ;
      StCalc: begin
        busy  = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (trial_borrow) begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = sub_diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Start is honoured outside CALC; this overrides the DONE->IDLE return.
    if (start && (state_q != StCalc)) begin
      state_d = StCalc;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = dividend;
      dvs_d   = divisor;
`ifdef DIV6_SEQ_DIVZERO_EN
      dbz_d   = 1'b0;
      if (divisor == '0) begin
        state_d = StDone;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div6_seq.sv
// Directed self-checking bench for div6_seq (WIDTH = 6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div6_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [5:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       dbz;

  int total = 0;
  int bad   = 0;

  div6_seq #(
    .WIDTH(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents start for one rising edge.
  task automatic issue(input logic [5:0] a, input logic [5:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat0 = cycles already elapsed since the accepting edge. Returns on the
  // falling edge where done is high (or after the cycle budget runs out).
  task automatic wait_result(input string tag, input int lat0, input int exp_lat,
                             input int exp_busy, input int exp_q, input int exp_r,
                             input int exp_z);
    int lat = lat0;
    int bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bc, exp_busy);
    chk({tag, "_q"}, int'(quotient), exp_q);
    chk({tag, "_r"}, int'(remainder), exp_r);
    chk({tag, "_dbz"}, int'(dbz), exp_z);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dbz", int'(dbz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 45/7: six CALC cycles, done in the 7th cycle after start.
    issue(6'd45, 6'd7);
    wait_result("d45_7", 1, 7, 6, 6, 3, 0);
    @(negedge clk);
    chk("hold_done", int'(done), 0);
    chk("hold_busy", int'(busy), 0);
    chk("hold_q", int'(quotient), 6);
    chk("hold_r", int'(remainder), 3);

    issue(6'd63, 6'd1);
    wait_result("d63_1", 1, 7, 6, 63, 0, 0);
    @(negedge clk);
    issue(6'd5, 6'd9);
    wait_result("d5_9", 1, 7, 6, 0, 5, 0);
    @(negedge clk);
    issue(6'd0, 6'd13);
    wait_result("d0_13", 1, 7, 6, 0, 0, 0);
    @(negedge clk);

    // Divide by zero.
    issue(6'd20, 6'd0);
`ifdef DIV6_SEQ_DIVZERO_EN
    wait_result("d20_0", 1, 1, 0, 63, 20, 1);
`else
    wait_result("d20_0", 1, 7, 6, 63, 20, 0);
`endif
    @(negedge clk);

    // Start pulsed mid-CALC must be ignored.
    issue(6'd45, 6'd7);
    start    = 1'b1;
    dividend = 6'd50;
    divisor  = 6'd3;
    @(negedge clk);
    start = 1'b0;
    wait_result("ign", 2, 7, 5, 6, 3, 0);
    @(negedge clk);

    // Asynchronous reset in CALC cycle 3.
    issue(6'd45, 6'd7);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_q", int'(quotient), 0);
    chk("arst_r", int'(remainder), 0);
    chk("arst_dbz", int'(dbz), 0);
    @(negedge clk);
    chk("arst_idle_busy", int'(busy), 0);
    rst_n = 1'b1;
    issue(6'd60, 6'd4);
    wait_result("d60_4", 1, 7, 6, 15, 0, 0);
    @(negedge clk);

    // Back-to-back: start held through DONE re-enters CALC at once.
    issue(6'd45, 6'd7);
    wait_result("b2b_a", 1, 7, 6, 6, 3, 0);
    issue(6'd62, 6'd5);
    chk("b2b_reenter", int'(busy), 1);
    wait_result("b2b_b", 1, 7, 6, 12, 2, 0);
    @(negedge clk);
    chk("b2b_idle", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
